// File: rtl/cpu_seq_pkg.sv
// Shared definitions for CPU-level controllers: sequencer state encoding and default widths.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        START,
        WAIT,
        NEXT,
        DONE
    } seq_state_t;

    localparam int DEF_PROG_W = 2;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating cycle counter: load to 1, increment, hold at all-ones, flag when next value hits LIMIT.
module sat_counter #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] next_count,
    output logic             at_limit
);

    logic [CNT_W-1:0] count;

    // next_count is the count including the current cycle, so callers can capture it on exit
    assign next_count = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    assign at_limit   = (64'(next_count) == 64'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc) begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Runs CPU programs 0..NumProgs-1 back to back and reports per-program cycle counts.
// Optional watchdog enabled by defining RUN_WATCHDOG_EN.
module cpu_run_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PROG_W     = DEF_PROG_W,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WDOG_LIMIT = 4096
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic [PROG_W:0]   NumProgs,
    output logic              CpuReset,
    output logic              CpuStart,
    output logic [PROG_W-1:0] CpuProgSel,
    input  logic              CpuAck,
    output logic              RunValid,
    output logic [PROG_W-1:0] RunIdx,
    output logic [CNT_W-1:0]  RunCycles,
    output logic              Busy,
    output logic              Done,
    output logic              Timeout
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [PROG_W:0] MAX_PROGS = (PROG_W + 1)'(2 ** PROG_W);

    seq_state_t        state, state_n;
    logic [PROG_W-1:0] idx;
    logic [PROG_W:0]   num, num_clamped;
    logic [RC_W-1:0]   rst_cnt;
    logic              cnt_load, cnt_inc, at_limit, wdog_hit, last_prog, go_ok;
    logic [CNT_W-1:0]  count_next;

    assign num_clamped = (NumProgs > MAX_PROGS) ? MAX_PROGS : NumProgs;
    assign last_prog   = (({1'b0, idx} + (PROG_W + 1)'(1)) == num);
    assign go_ok       = Go && ((state == IDLE) || (state == DONE));

    sat_counter #(
        .CNT_W (CNT_W),
        .LIMIT (WDOG_LIMIT)
    ) u_cnt (
        .clk        (Clk),
        .rst_n      (Reset),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .next_count (count_next),
        .at_limit   (at_limit)
    );

`ifdef RUN_WATCHDOG_EN
    // A same-cycle Ack takes priority over the watchdog
    assign wdog_hit = at_limit && !CpuAck;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Timeout <= 1'b0;
        end else if (go_ok) begin
            Timeout <= 1'b0;
        end else if ((state == WAIT) && wdog_hit) begin
            Timeout <= 1'b1;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = at_limit;
    assign wdog_hit     = 1'b0;
    assign Timeout      = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE, DONE: if (Go) state_n = (NumProgs == '0) ? DONE : RST;
            RST:        if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_n = START;
            START: begin
                cnt_load = 1'b1;
                state_n  = WAIT;
            end
            WAIT: begin
                cnt_inc = 1'b1;
                if (CpuAck || wdog_hit) state_n = NEXT;
            end
            NEXT:       state_n = last_prog ? DONE : RST;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            idx       <= '0;
            num       <= '0;
            rst_cnt   <= '0;
            RunIdx    <= '0;
            RunCycles <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE: begin
                    if (Go) begin
                        num <= num_clamped;
                        idx <= '0;
                    end
                end
                RST:  rst_cnt <= (state_n == START) ? '0 : rst_cnt + RC_W'(1);
                WAIT: begin
                    if (state_n == NEXT) begin
                        RunIdx    <= idx;
                        RunCycles <= count_next;
                    end
                end
                NEXT: if (!last_prog) idx <= idx + PROG_W'(1);
                default: ;
            endcase
        end
    end

    assign CpuReset   = (state == IDLE) || (state == RST) || (state == DONE);
    assign CpuStart   = (state == START);
    assign CpuProgSel = idx;
    assign RunValid   = (state == NEXT);
    assign Busy       = !((state == IDLE) || (state == DONE));
    assign Done       = (state == DONE);

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer with a simple CPU ack model; second instance uses CNT_W=4.
module tb_cpu_run_sequencer;

    localparam int PROG_W = 2;

    logic              Clk = 1'b0;
    logic              Reset, Go;
    logic              CpuAck = 1'b0;
    logic [PROG_W:0]   NumProgs;
    logic              CpuReset, CpuStart, RunValid, Busy, Done, Timeout;
    logic [PROG_W-1:0] CpuProgSel, RunIdx;
    logic [15:0]       RunCycles;
    logic              b_CpuReset, b_CpuStart, b_RunValid, b_Busy, b_Done, b_Timeout;
    logic [PROG_W-1:0] b_CpuProgSel, b_RunIdx;
    logic [3:0]        b_RunCycles;

    always #5 Clk = ~Clk;

    cpu_run_sequencer #(.PROG_W(PROG_W), .RST_CYCLES(2), .CNT_W(16), .WDOG_LIMIT(16)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs),
        .CpuReset(CpuReset), .CpuStart(CpuStart), .CpuProgSel(CpuProgSel), .CpuAck(CpuAck),
        .RunValid(RunValid), .RunIdx(RunIdx), .RunCycles(RunCycles),
        .Busy(Busy), .Done(Done), .Timeout(Timeout)
    );

    cpu_run_sequencer #(.PROG_W(PROG_W), .RST_CYCLES(2), .CNT_W(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .Go(Go), .NumProgs(NumProgs),
        .CpuReset(b_CpuReset), .CpuStart(b_CpuStart), .CpuProgSel(b_CpuProgSel), .CpuAck(CpuAck),
        .RunValid(b_RunValid), .RunIdx(b_RunIdx), .RunCycles(b_RunCycles),
        .Busy(b_Busy), .Done(b_Done), .Timeout(b_Timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // CPU model: Ack in cycle (start cycle + dly[prog]); sticky keeps Ack high afterwards
    int   dly[4];
    bit   sticky = 1'b0;
    bit   model_clr = 1'b1;
    bit   counting = 1'b0;
    int   k = 0;
    int   cur = 0;
    logic st_s;
    logic [PROG_W-1:0] ps_s;

    always begin
        @(negedge Clk);
        st_s = CpuStart;
        ps_s = CpuProgSel;
        @(posedge Clk);
        #1;
        if (model_clr) begin
            CpuAck   = 1'b0;
            counting = 1'b0;
        end else begin
            if (st_s) begin
                k        = 1;
                counting = 1'b1;
                cur      = dly[ps_s];
            end else if (counting) begin
                k++;
            end
            if (counting && k == cur) begin
                CpuAck   = 1'b1;
                counting = 1'b0;
            end else if (!sticky) begin
                CpuAck = 1'b0;
            end
        end
    end

    // Monitor: run reports, and CpuReset-high run length preceding each CpuStart
    logic [PROG_W-1:0] rv_idx[$];
    int rv_cyc[$];
    int b_cyc[$];
    int rl[$];
    int rh = 0;

    always @(negedge Clk) begin
        if (RunValid) begin
            rv_idx.push_back(RunIdx);
            rv_cyc.push_back(int'(RunCycles));
        end
        if (b_RunValid) b_cyc.push_back(int'(b_RunCycles));
        if (CpuReset && Busy) begin
            rh++;
        end else begin
            if (CpuStart) rl.push_back(rh);
            rh = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic go(input int n);
        @(posedge Clk);
        #1;
        Go       = 1'b1;
        NumProgs = (PROG_W + 1)'(n);
        @(posedge Clk);
        #1;
        Go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit both, input int budget);
        int i = 0;
        while (!(Done && (!both || b_Done)) && i < budget) begin
            @(negedge Clk);
            i++;
        end
        chk(tag, Done, 1);
    endtask

    task automatic chk_run(input string tag, input int pos, input int exp_idx, input int exp_cyc);
        if (pos < rv_idx.size()) begin
            chk({tag, "_idx"}, rv_idx[pos], exp_idx);
            chk({tag, "_cyc"}, rv_cyc[pos], exp_cyc);
        end else begin
            chk({tag, "_present"}, 0, 1);
        end
    endtask

    int r0, s0, b0, i;

    initial begin
        Reset    = 1'b0;
        Go       = 1'b0;
        NumProgs = '0;
        dly      = '{5, 5, 5, 5};
        repeat (3) @(negedge Clk);
        chk("rst_cpureset", CpuReset, 1);
        chk("rst_cpustart", CpuStart, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_runvalid", RunValid, 0);
        chk("rst_runidx", RunIdx, 0);
        chk("rst_runcycles", RunCycles, 0);
        chk("rst_timeout", Timeout, 0);
        chk("rst_progsel", CpuProgSel, 0);
        @(posedge Clk);
        #1;
        Reset     = 1'b1;
        model_clr = 1'b0;
        tick(2);

        // NumProgs=0 from IDLE goes straight to DONE
        chk("np0_pre_done", Done, 0);
        s0 = rl.size();
        r0 = rv_idx.size();
        go(0);
        chk("np0_done", Done, 1);
        chk("np0_busy", Busy, 0);
        tick(3);
        chk("np0_nostart", rl.size() - s0, 0);
        chk("np0_norv", rv_idx.size() - r0, 0);
        chk("np0_cpureset", CpuReset, 1);

        // Three programs, Ack 5 cycles after Start
        s0 = rl.size();
        r0 = rv_idx.size();
        b0 = b_cyc.size();
        go(3);
        wait_done("t2_done", 1'b1, 300);
        chk("t2_nrv", rv_idx.size() - r0, 3);
        for (int j = 0; j < 3; j++) begin
            chk_run("t2_run", r0 + j, j, 6);
            if (s0 + j < rl.size()) chk("t2_rstlen", rl[s0 + j], 2);
            else chk("t2_start_present", 0, 1);
        end
        if (b0 < b_cyc.size()) chk("t2_b_cyc", b_cyc[b0], 6);
        else chk("t2_b_present", 0, 1);
        chk("t2_busy", Busy, 0);
        chk("t2_cpureset", CpuReset, 1);

        // Ack held high from previous run is ignored in RST/START
        r0 = rv_idx.size();
        dly[0] = 3;
        dly[1] = 1;
        sticky = 1'b1;
        go(2);
        wait_done("t4_done", 1'b1, 300);
        chk("t4_nrv", rv_idx.size() - r0, 2);
        chk_run("t4_run0", r0, 0, 4);
        chk_run("t4_run1", r0 + 1, 1, 2);
        sticky    = 1'b0;
        model_clr = 1'b1;
        tick(2);
        model_clr = 1'b0;
        dly = '{5, 5, 5, 5};

        // Saturation on CNT_W=4 instance; Go while Busy has no effect
        r0 = rv_idx.size();
        b0 = b_cyc.size();
        dly[0] = 19;
        go(1);
        tick(5);
        chk("t6_busy_at_go", Busy, 1);
        Go       = 1'b1;
        NumProgs = 3'd3;
        tick(1);
        Go = 1'b0;
        wait_done("t6_done", 1'b1, 300);
        chk("t6_nrv", rv_idx.size() - r0, 1);
        chk("t6_b_nrv", b_cyc.size() - b0, 1);
        if (b0 < b_cyc.size()) chk("t6_b_sat", b_cyc[b0], 15);
`ifdef RUN_WATCHDOG_EN
        chk_run("t6_run", r0, 0, 16);
`else
        chk_run("t6_run", r0, 0, 20);
`endif
        dly = '{5, 5, 5, 5};
        tick(2);

        // Asynchronous reset mid-WAIT of program 1
        s0 = rl.size();
        r0 = rv_idx.size();
        go(3);
        i = 0;
        while (rl.size() < s0 + 2 && i < 200) begin
            @(negedge Clk);
            i++;
        end
        chk("t1_reach_p1", rl.size() - s0, 2);
        repeat (2) @(negedge Clk);
        #2;
        Reset     = 1'b0;
        model_clr = 1'b1;
        #1;
        chk("t1_cpureset", CpuReset, 1);
        chk("t1_busy", Busy, 0);
        chk("t1_runvalid", RunValid, 0);
        chk("t1_cpustart", CpuStart, 0);
        chk("t1_progsel", CpuProgSel, 0);
        chk("t1_timeout", Timeout, 0);
        repeat (3) @(negedge Clk);
        chk("t1_norv_abort", rv_idx.size() - r0, 1);
        @(posedge Clk);
        #1;
        Reset     = 1'b1;
        model_clr = 1'b0;
        tick(1);
        r0 = rv_idx.size();
        go(2);
        wait_done("t1_restart_done", 1'b1, 300);
        chk("t1_restart_nrv", rv_idx.size() - r0, 2);
        chk_run("t1_restart0", r0, 0, 6);
        chk_run("t1_restart1", r0 + 1, 1, 6);

        // Watchdog: program 0 never acks, program 1 acks normally
        r0 = rv_idx.size();
        dly[0] = 100000;
        dly[1] = 5;
        go(2);
`ifdef RUN_WATCHDOG_EN
        wait_done("t5_done", 1'b0, 300);
        chk("t5_nrv", rv_idx.size() - r0, 2);
        chk_run("t5_run0", r0, 0, 16);
        chk_run("t5_run1", r0 + 1, 1, 6);
        chk("t5_timeout", Timeout, 1);
        go(0);
        chk("t5_timeout_clr", Timeout, 0);
`else
        tick(100);
        chk("t5_busy_hold", Busy, 1);
        chk("t5_timeout_tied", Timeout, 0);
        chk("t5_nrv", rv_idx.size() - r0, 0);
        chk("t5_progsel", CpuProgSel, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
